// File: rtl/spad_pkg.sv
// Shared types and constants for the scratchpad stream reader.
package spad_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

   localparam int unsigned SKID_DEPTH = 2;
   localparam int unsigned SKID_CNT_BITS = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/spad_skid_fifo.sv
// Two-entry skid FIFO; entry0 is always the head so the output needs no read mux.
module spad_skid_fifo
   import spad_pkg::*;
#(
   parameter int unsigned WIDTH = 17
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         head,
   output logic [SKID_CNT_BITS-1:0] count
);

   logic [WIDTH-1:0]         entry0_q;
   logic [WIDTH-1:0]         entry1_q;
   logic [SKID_CNT_BITS-1:0] count_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         entry0_q <= '0;
         entry1_q <= '0;
         count_q  <= '0;
      end else if (push && pop) begin
         // Occupancy unchanged; the new word lands behind whatever survives the pop.
         if (count_q == SKID_CNT_BITS'(2)) begin
            entry0_q <= entry1_q;
            entry1_q <= wdata;
         end else begin
            entry0_q <= wdata;
         end
      end else if (pop) begin
         entry0_q <= entry1_q;
         count_q  <= count_q - SKID_CNT_BITS'(1);
      end else if (push) begin
         if (count_q == '0) begin
            entry0_q <= wdata;
         end else begin
            entry1_q <= wdata;
         end
         count_q <= count_q + SKID_CNT_BITS'(1);
      end
   end

   assign head  = entry0_q;
   assign count = count_q;

endmodule

// File: rtl/spad_stream_reader.sv
// Strided scratchpad read sequencer feeding a valid/ready stream through a skid FIFO.
module spad_stream_reader
   import spad_pkg::*;
#(
   parameter int unsigned DATA_BITWIDTH = 16,
   parameter int unsigned ADDR_BITWIDTH = 9
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_start,
   input  logic [ADDR_BITWIDTH-1:0] i_base_addr,
   input  logic [ADDR_BITWIDTH-1:0] i_stride,
   input  logic [ADDR_BITWIDTH:0]   i_length,
   output logic                     o_busy,
   output logic                     o_done,
   output logic                     o_spad_ren,
   output logic [ADDR_BITWIDTH-1:0] o_spad_raddr,
   input  logic [DATA_BITWIDTH-1:0] i_spad_rdata,
   output logic                     o_valid,
   input  logic                     i_ready,
   output logic [DATA_BITWIDTH-1:0] o_data,
   output logic                     o_last
);

   localparam int unsigned CW = ADDR_BITWIDTH + 1;

   state_e                   state_q;
   logic [ADDR_BITWIDTH-1:0] addr_q;
   logic [ADDR_BITWIDTH-1:0] stride_q;
   logic [ADDR_BITWIDTH-1:0] raddr_q;
   logic [CW-1:0]            length_q;
   logic [CW-1:0]            issue_cnt_q;
   logic                     inflight_q;
   logic                     inflight_last_q;
   logic                     busy_q;
   logic                     done_q;

   logic [SKID_CNT_BITS-1:0] fifo_count;
   logic [DATA_BITWIDTH:0]   fifo_head;
   logic                     pop;
   logic                     ren;
   logic                     last_issue;

   assign o_valid = (fifo_count != '0);
   assign pop     = o_valid && i_ready;
   assign o_data  = fifo_head[DATA_BITWIDTH-1:0];
   assign o_last  = fifo_head[DATA_BITWIDTH];

   // The in-flight word already owns a FIFO slot; a pop this cycle frees one.
   assign ren = (state_q == ISSUE) &&
                ({1'b0, fifo_count} + {2'b00, inflight_q} <
                 3'(SKID_DEPTH) + {2'b00, pop});

   assign last_issue   = (issue_cnt_q == length_q - CW'(1));
   assign o_spad_ren   = ren;
   assign o_spad_raddr = ren ? addr_q : raddr_q;
   assign o_busy       = busy_q;
   assign o_done       = done_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= IDLE;
         addr_q          <= '0;
         stride_q        <= '0;
         raddr_q         <= '0;
         length_q        <= '0;
         issue_cnt_q     <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
      end else begin
         inflight_q      <= ren;
         inflight_last_q <= ren && last_issue;
         unique case (state_q)
            IDLE: begin
               if (i_start) begin
                  addr_q      <= i_base_addr;
                  stride_q    <= i_stride;
                  length_q    <= i_length;
                  issue_cnt_q <= '0;
                  if (i_length != '0) begin
                     state_q <= ISSUE;
                     busy_q  <= 1'b1;
                  end else begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               if (ren) begin
                  raddr_q     <= addr_q;
                  addr_q      <= addr_q + stride_q;
                  issue_cnt_q <= issue_cnt_q + CW'(1);
                  if (last_issue) begin
                     state_q <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (pop && o_last) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   spad_skid_fifo #(
      .WIDTH(DATA_BITWIDTH + 1)
   ) u_fifo (
      .clk  (clk),
      .reset(reset),
      .push (inflight_q),
      .pop  (pop),
      .wdata({inflight_last_q, i_spad_rdata}),
      .head (fifo_head),
      .count(fifo_count)
   );

endmodule

// File: tb/tb_spad_stream_reader.sv
// Directed bench: command table plus hand-written reset-abort sequence.
module tb_spad_stream_reader;

   localparam int unsigned DW = 16;
   localparam int unsigned AW = 9;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          i_start = 1'b0;
   logic [AW-1:0] i_base_addr = '0;
   logic [AW-1:0] i_stride = '0;
   logic [AW:0]   i_length = '0;
   logic          o_busy;
   logic          o_done;
   logic          o_spad_ren;
   logic [AW-1:0] o_spad_raddr;
   logic [DW-1:0] i_spad_rdata = '0;
   logic          o_valid;
   logic          i_ready = 1'b1;
   logic [DW-1:0] o_data;
   logic          o_last;

   logic [DW-1:0] mem [0:(1<<AW)-1];

   int n_cmp = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   // Scratchpad model: registered read, zero when not enabled.
   always @(posedge clk) i_spad_rdata <= o_spad_ren ? mem[o_spad_raddr] : '0;

   spad_stream_reader #(
      .DATA_BITWIDTH(DW),
      .ADDR_BITWIDTH(AW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .i_start     (i_start),
      .i_base_addr (i_base_addr),
      .i_stride    (i_stride),
      .i_length    (i_length),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_spad_ren  (o_spad_ren),
      .o_spad_raddr(o_spad_raddr),
      .i_spad_rdata(i_spad_rdata),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_data      (o_data),
      .o_last      (o_last)
   );

   typedef struct {
      logic [AW-1:0] base;
      logic [AW-1:0] stride;
      logic [AW:0]   len;
      bit            toggle;
      logic [AW-1:0] last_addr;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_busy"}, o_busy, 0);
      check({tag, "_done"}, o_done, 0);
      check({tag, "_ren"}, o_spad_ren, 0);
      check({tag, "_raddr"}, o_spad_raddr, 0);
      check({tag, "_valid"}, o_valid, 0);
      check({tag, "_data"}, o_data, 0);
      check({tag, "_last"}, o_last, 0);
   endtask

   task automatic run_cmd(input vec_t v);
      int            issued = 0;
      int            popped = 0;
      int            done_cnt = 0;
      int            done_idx = -1;
      int            first_beat = -1;
      int            last_beat = -1;
      int            bound;
      logic [AW-1:0] last_raddr = '0;
      logic [AW-1:0] exp_addr;
      logic          pop;
      logic          prev_stall = 1'b0;
      logic [DW-1:0] prev_data = '0;
      logic          prev_last = 1'b0;
      bound = 3 * int'(v.len) + 20;
      i_base_addr = v.base;
      i_stride    = v.stride;
      i_length    = v.len;
      i_start     = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      for (int c = 0; c < bound; c++) begin
         i_ready = v.toggle ? (c % 2 == 0) : 1'b1;
         // A start mid-command must be ignored.
         if (c == 1 && v.len != 0) begin
            i_start     = 1'b1;
            i_base_addr = 9'd300;
            i_length    = 10'd2;
         end else begin
            i_start = 1'b0;
         end
         #1;
         pop = o_valid && i_ready;
         if (c == 0 && v.len != 0) check("busy_after_start", o_busy, 1);
         if (o_spad_ren) begin
            exp_addr = v.base + AW'(issued) * v.stride;
            check("raddr", o_spad_raddr, exp_addr);
            check("ren_occupancy", (issued - popped - int'(pop)) < 2, 1);
            issued++;
            last_raddr = o_spad_raddr;
         end
         if (o_valid && prev_stall) begin
            check("stall_hold_data", o_data, prev_data);
            check("stall_hold_last", o_last, prev_last);
         end
         if (pop) begin
            exp_addr = v.base + AW'(popped) * v.stride;
            check("data", o_data, mem[exp_addr]);
            check("last", o_last, popped == int'(v.len) - 1);
            if (first_beat < 0) first_beat = c;
            last_beat = c;
            popped++;
         end
         if (o_done) begin
            done_cnt++;
            done_idx = c;
         end
         prev_stall = o_valid && !i_ready;
         prev_data  = o_data;
         prev_last  = o_last;
         if (done_idx >= 0 && c >= done_idx + 3) break;
         @(posedge clk); #1;
      end
      i_start = 1'b0;
      i_ready = 1'b1;
      check("reads_issued", issued, v.len);
      check("beats", popped, v.len);
      check("done_pulses", done_cnt, 1);
      if (v.len == 0) begin
         check("done_idx_len0", done_idx, 0);
      end else begin
         check("first_beat_cycle", first_beat, 2);
         check("done_after_last", done_idx, last_beat + 1);
         check("last_raddr", last_raddr, v.last_addr);
         if (!v.toggle) check("back_to_back", last_beat - first_beat, int'(v.len) - 1);
      end
   endtask

   initial begin
      vec_t vecs[7];
      int   beats;

      for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i + 100);

      vecs[0] = '{base: 9'd0,   stride: 9'd1, len: 10'd4,   toggle: 1'b0, last_addr: 9'd3};
      vecs[1] = '{base: 9'd510, stride: 9'd3, len: 10'd3,   toggle: 1'b0, last_addr: 9'd4};
      vecs[2] = '{base: 9'd40,  stride: 9'd5, len: 10'd8,   toggle: 1'b1, last_addr: 9'd75};
      vecs[3] = '{base: 9'd12,  stride: 9'd2, len: 10'd0,   toggle: 1'b0, last_addr: 9'd0};
      vecs[4] = '{base: 9'd7,   stride: 9'd0, len: 10'd3,   toggle: 1'b0, last_addr: 9'd7};
      vecs[5] = '{base: 9'd500, stride: 9'd7, len: 10'd5,   toggle: 1'b1, last_addr: 9'd16};
      vecs[6] = '{base: 9'd0,   stride: 9'd1, len: 10'd512, toggle: 1'b0, last_addr: 9'd511};

      reset = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      check_outputs_zero("reset");
      reset = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 7; i++) run_cmd(vecs[i]);

      // Reset lands on the 3rd beat of a 6-word command.
      i_base_addr = 9'd0;
      i_stride    = 9'd1;
      i_length    = 10'd6;
      i_ready     = 1'b1;
      i_start     = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      beats = 0;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (o_valid) beats++;
         if (beats == 3) begin
            reset = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      check("abort_reached_beat3", beats, 3);
      @(posedge clk); #2;
      check_outputs_zero("abort");
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #2;
         check("abort_no_valid", o_valid, 0);
         check("abort_no_done", o_done, 0);
         check("abort_no_ren", o_spad_ren, 0);
      end
      @(posedge clk); #1;
      run_cmd('{base: 9'd20, stride: 9'd2, len: 10'd3, toggle: 1'b0, last_addr: 9'd24});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
